// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S single-channel receiver producing one-cycle-valid signed Q15 samples
// Optional rounding with saturation when I2S_RX_ROUND_EN is defined; truncation otherwise.
module i2s_rx #(
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 24,
    parameter int OUT_BITS  = 16,
    parameter int CHANNEL   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       i2s_sck,
    input  logic                       i2s_ws,
    input  logic                       i2s_sd,
    output logic signed [OUT_BITS-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       frame_err,
    output logic                       locked
);

    typedef enum logic [1:0] {UNLOCKED, OTHER, CAPTURE, DONE} state_t;

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int SW = $clog2(SLOT_BITS + 2);

    state_t               state, state_next;
    logic                 sck_s1, sck_s2, sck_s3;
    logic                 ws_s1, ws_s2, sd_s1, sd_s2;
    logic                 ws_prev;
    logic [BW-1:0]        bit_cnt;
    logic [SW-1:0]        slot_cnt;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [OUT_BITS-1:0]  trunc, out_val;
    logic                 rise, boundary, ws_is_ch;
    logic                 do_shift, emit, err;

    assign rise       = sck_s2 & ~sck_s3;
    assign boundary   = rise & (ws_s2 != ws_prev);
    assign ws_is_ch   = (ws_s2 == (CHANNEL != 0));
    assign shreg_next = {shreg[DATA_BITS-2:0], sd_s2};
    assign trunc      = shreg_next[DATA_BITS-1 -: OUT_BITS];
    assign locked     = (state != UNLOCKED);

`ifdef I2S_RX_ROUND_EN
    logic rbit;
    assign rbit = shreg_next[DATA_BITS-OUT_BITS-1];
    // Only the most positive code can overflow when adding the half-LSB.
    always_comb begin
        out_val = trunc + {{(OUT_BITS-1){1'b0}}, rbit};
        if (rbit && trunc == {1'b0, {(OUT_BITS-1){1'b1}}})
            out_val = trunc;
    end
`else
    assign out_val = trunc;
`endif

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        emit       = 1'b0;
        err        = 1'b0;
        if (!enable) begin
            state_next = UNLOCKED;
        end else if (boundary) begin
            // A boundary mid-capture is a short slot; it still starts the next slot.
            err        = (state == CAPTURE);
            state_next = ws_is_ch ? CAPTURE : OTHER;
        end else if (rise && state != UNLOCKED && slot_cnt == SW'(SLOT_BITS)) begin
            err        = 1'b1;
            state_next = UNLOCKED;
        end else if (rise && state == CAPTURE) begin
            do_shift = 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
                emit       = 1'b1;
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= UNLOCKED;
            sck_s1       <= 1'b0;
            sck_s2       <= 1'b0;
            sck_s3       <= 1'b0;
            ws_s1        <= 1'b0;
            ws_s2        <= 1'b0;
            sd_s1        <= 1'b0;
            sd_s2        <= 1'b0;
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            slot_cnt     <= '0;
            shreg        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sck_s1       <= i2s_sck;
            sck_s2       <= sck_s1;
            sck_s3       <= sck_s2;
            ws_s1        <= i2s_ws;
            ws_s2        <= ws_s1;
            sd_s1        <= i2s_sd;
            sd_s2        <= sd_s1;
            state        <= state_next;
            sample_valid <= emit;
            frame_err    <= err;
            if (rise)
                ws_prev <= ws_s2;
            if (boundary) begin
                bit_cnt  <= '0;
                slot_cnt <= '0;
                shreg    <= '0;
            end else if (rise) begin
                if (slot_cnt != SW'(SLOT_BITS))
                    slot_cnt <= slot_cnt + SW'(1);
                if (do_shift) begin
                    shreg   <= shreg_next;
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
            if (emit)
                sample_out <= out_val;
        end
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Front-end capture stage for the vocal path: deserialises an I2S microphone stream into signed Q15 samples, one channel only.
- Output is a one-cycle-valid sample stream at the 16 kHz frame rate. It connects directly to the FIR's x_in/x_in_valid inputs.
- I2S pins are treated as asynchronous to clk. They are synchronised and edge-detected internally; the block never clocks on i2s_sck.

Parameters:
- SLOT_BITS, 32: SCK periods per channel slot (nominal; used for the overrun check).
- DATA_BITS, 24: significant MSB-first bits captured per slot. Must be ≥ OUT_BITS+1 and ≤ SLOT_BITS.
- OUT_BITS, 16: output sample width (Q15).
- CHANNEL, 0: captured slot. 0 = left (ws low), 1 = right (ws high).

Ports:
- clk  in  1  system clock; must be ≥ 8× i2s_sck frequency.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, the block drops lock and suppresses output.
- i2s_sck  in  1  I2S bit clock (async).
- i2s_ws  in  1  I2S word select (async).
- i2s_sd  in  1  I2S serial data (async).
- sample_out  out  OUT_BITS  signed captured sample; holds its value between valids.
- sample_valid  out  1  one-clk pulse when sample_out updates.
- frame_err  out  1  one-clk pulse on a malformed slot.
- locked  out  1  high once a WS edge has been seen while enabled.

Behaviour:
- Reset values: sample_out=0, sample_valid=0, frame_err=0, locked=0. All internal registers are cleared to 0. State is UNLOCKED.
- Synchronisation:
  - sck, ws and sd each pass through 2 flops, then a third history flop for sck.
  - A rise event fires in the cycle where sck_s2=1 and sck_s3=0.
  - ws and sd are sampled only on rise events, using their s2 values.
- Slot boundary: a rise event whose sampled ws differs from the previously sampled ws.
  - The sd bit at that event is the delay bit and is discarded.
  - bit_cnt resets to 0.
  - The next rise event carries the MSB.
- States:
  - UNLOCKED: wait for a slot boundary. On a boundary, set locked=1. Go to CAPTURE if the new ws == CHANNEL, otherwise OTHER.
  - OTHER: ignore sd. On a boundary into CHANNEL, go to CAPTURE.
  - CAPTURE: shift sd into shreg MSB-first; bit_cnt++ per rise event. After bit DATA_BITS-1 is shifted in, go to DONE.
  - DONE: ignore the remaining bits. On a boundary, go to OTHER (or CAPTURE if the ws value is unchanged logically impossible; treat as OTHER).
- Output timing:
  - sample_valid asserts in the clk cycle after the rise event that captured bit DATA_BITS-1.
  - sample_out updates in that same cycle.
  - Default sample_out = shreg[DATA_BITS-1 -: OUT_BITS], i.e. truncation.
- Short slot: a boundary arriving while in CAPTURE with bit_cnt < DATA_BITS. Response:
  - pulse frame_err the next cycle;
  - no sample_valid;
  - discard shreg;
  - proceed as a normal boundary.
- Overrun: more than SLOT_BITS rise events since the last boundary. Response:
  - pulse frame_err once;
  - clear locked;
  - go to UNLOCKED.
- enable low: go to UNLOCKED next cycle, locked=0, no valid/err pulses. sample_out holds its last value.
- Reset mid-slot: all state is cleared. The first valid comes only after a fresh boundary and a full capture; the partial word is never emitted.
- Simultaneous events: a boundary on the same rise event as the final capture bit cannot occur when DATA_BITS < SLOT_BITS. If DATA_BITS == SLOT_BITS, the boundary takes priority and the slot counts as short.

Optional Feature:
- Macro I2S_RX_ROUND_EN.
- Defined: sample_out = round-half-up of shreg to OUT_BITS. This adds bit DATA_BITS-OUT_BITS-1 to the truncated value and saturates to 0x7FFF on positive overflow. Latency is unchanged: the add and saturate are combinational into the output register.
- Undefined: plain truncation as described above.

Test Plan:
- Left slot 0x123456, right slot 0xABCDEF, CHANNEL=0, 32-bit slots, clk=50 MHz, sck=1.024 MHz -> locked high after the first WS edge; one sample_valid per frame; sample_out=0x1234. The right data never appears.
- Same stream with CHANNEL=1 -> sample_out=0xABCD (signed −21555).
- Left slot 0x800000, then 0x7FFFFF -> 0x8000, then 0x7FFF. Exactly one valid per frame over 10 frames; valid spacing = 62.5 µs.
- WS toggles after only 10 data bits in the left slot -> frame_err pulse, no sample_valid that frame. The next full frame outputs normally.
- reset asserted for 1 clk midway through the left capture -> all outputs 0 and locked=0 the following cycle. The next valid carries the next complete left word, never a partial one.
- With I2S_RX_ROUND_EN: 0x123480 -> 0x1235; 0x7FFFC0 -> 0x7FFF (saturated). Without it: 0x1234 and 0x7FFF respectively.
